// File: rtl/ncpu32k_lsu_if.sv
// Execute-stage op/result handshakes plus the dcache command/response channel.
// slave = the LSU side, master = the pipeline/dcache environment driving it.
interface ncpu32k_lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          lsu_op_valid;
  logic          lsu_op_ready;
  logic          lsu_op_load;
  logic [2:0]    lsu_op_size;
  logic          lsu_op_sign;
  logic [AW-1:0] lsu_op_addr;
  logic [DW-1:0] lsu_op_wdat;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [DW-1:0] lsu_dout;
  logic          lsu_exc_align;
  logic          dcache_cmd_valid;
  logic          dcache_cmd_ready;
  logic [AW-1:0] dcache_cmd_addr;
  logic [2:0]    dcache_cmd_size;
  logic          dcache_cmd_we;
  logic [DW-1:0] dcache_din;
  logic          dcache_valid;
  logic          dcache_ready;
  logic [DW-1:0] dcache_dout;

  modport slave (
    input  lsu_op_valid, lsu_op_load, lsu_op_size, lsu_op_sign, lsu_op_addr, lsu_op_wdat,
    input  lsu_ready, dcache_cmd_ready, dcache_valid, dcache_dout,
    output lsu_op_ready, lsu_valid, lsu_dout, lsu_exc_align,
    output dcache_cmd_valid, dcache_cmd_addr, dcache_cmd_size, dcache_cmd_we, dcache_din, dcache_ready
  );

  modport master (
    output lsu_op_valid, lsu_op_load, lsu_op_size, lsu_op_sign, lsu_op_addr, lsu_op_wdat,
    output lsu_ready, dcache_cmd_ready, dcache_valid, dcache_dout,
    input  lsu_op_ready, lsu_valid, lsu_dout, lsu_exc_align,
    input  dcache_cmd_valid, dcache_cmd_addr, dcache_cmd_size, dcache_cmd_we, dcache_din, dcache_ready
  );
endinterface

// File: rtl/ncpu32k_lsu.sv
// Load/store unit: one op at a time, alignment check, lane placement, load extension.
// Latency op->result 3 cycles aligned (1 misaligned); every handshake holds its outputs until accepted.
module ncpu32k_lsu (
  input  logic         clk,
  input  logic         rst,
  ncpu32k_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [1:0]  sz_q;
  logic        sign_q;
  logic        load_q;

  logic [1:0]  op_size;
  logic        misalign;
  logic [31:0] wplace;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ldata;

  // Unknown size codes behave as word everywhere, including the dcache size field.
  always_comb begin
    op_size = 2'd2;
    if (bus.lsu_op_size == 3'd0) op_size = 2'd0;
    else if (bus.lsu_op_size == 3'd1) op_size = 2'd1;

    misalign = 1'b0;
    wplace   = bus.lsu_op_wdat;
    case (op_size)
      2'd0: wplace = {4{bus.lsu_op_wdat[7:0]}};
      2'd1: begin
        wplace   = {2{bus.lsu_op_wdat[15:0]}};
        misalign = bus.lsu_op_addr[0];
      end
      default: misalign = |bus.lsu_op_addr[1:0];
    endcase
  end

  always_comb begin
    lb = bus.dcache_dout[7:0];
    case (addr_lo)
      2'd1:    lb = bus.dcache_dout[15:8];
      2'd2:    lb = bus.dcache_dout[23:16];
      2'd3:    lb = bus.dcache_dout[31:24];
      default: lb = bus.dcache_dout[7:0];
    endcase
    lh = addr_lo[1] ? bus.dcache_dout[31:16] : bus.dcache_dout[15:0];

    ldata = bus.dcache_dout;
    case (sz_q)
      2'd0:    ldata = sign_q ? {{24{lb[7]}}, lb} : {24'd0, lb};
      2'd1:    ldata = sign_q ? {{16{lh[15]}}, lh} : {16'd0, lh};
      default: ldata = bus.dcache_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      addr_lo              <= 2'd0;
      sz_q                 <= 2'd0;
      sign_q               <= 1'b0;
      load_q               <= 1'b0;
      bus.lsu_op_ready     <= 1'b1;
      bus.lsu_valid        <= 1'b0;
      bus.lsu_exc_align    <= 1'b0;
      bus.lsu_dout         <= '0;
      bus.dcache_cmd_valid <= 1'b0;
      bus.dcache_ready     <= 1'b0;
      bus.dcache_cmd_addr  <= '0;
      bus.dcache_cmd_size  <= 3'd0;
      bus.dcache_cmd_we    <= 1'b0;
      bus.dcache_din       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.lsu_op_valid) begin
            addr_lo             <= bus.lsu_op_addr[1:0];
            sz_q                <= op_size;
            sign_q              <= bus.lsu_op_sign;
            load_q              <= bus.lsu_op_load;
            bus.dcache_cmd_addr <= {bus.lsu_op_addr[31:2], 2'b00};
            bus.dcache_cmd_size <= {1'b0, op_size};
            bus.dcache_cmd_we   <= ~bus.lsu_op_load;
            bus.dcache_din      <= wplace;
            bus.lsu_op_ready    <= 1'b0;
            if (misalign) begin
              // Misaligned ops never reach the dcache; report straight away.
              bus.lsu_exc_align <= 1'b1;
              bus.lsu_dout      <= '0;
              bus.lsu_valid     <= 1'b1;
              state             <= DONE;
            end else begin
              bus.lsu_exc_align    <= 1'b0;
              bus.dcache_cmd_valid <= 1'b1;
              state                <= CMD;
            end
          end
        end
        CMD: begin
          if (bus.dcache_cmd_ready) begin
            bus.dcache_cmd_valid <= 1'b0;
            bus.dcache_ready     <= 1'b1;
            state                <= RESP;
          end
        end
        RESP: begin
          if (bus.dcache_valid) begin
            bus.dcache_ready <= 1'b0;
            bus.lsu_dout     <= load_q ? ldata : 32'd0;
            bus.lsu_valid    <= 1'b1;
            state            <= DONE;
          end
        end
        DONE: begin
          if (bus.lsu_ready) begin
            bus.lsu_valid    <= 1'b0;
            bus.lsu_op_ready <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ncpu32k_lsu.sv
// Directed bench: stimulus pushes expected commands/results, dcache model and result monitor check them.
module tb_ncpu32k_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ncpu32k_lsu_if bus ();
  ncpu32k_lsu dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] din;
  } cmd_t;

  typedef struct {
    logic [31:0] dout;
    logic        exc;
    int          lat;
  } res_t;

  typedef struct {
    logic        load;
    logic [2:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          cs;
    int          rd;
    int          rs;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [31:0] e_din;
    logic [31:0] e_dout;
    logic        e_exc;
    int          e_lat;
  } vec_t;

  cmd_t exp_cmd[$];
  res_t exp_res[$];
  vec_t vt[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int ncmds = 0;
  int results_done = 0;
  int flush_req = 0;
  int cmd_stall = 0;
  int resp_delay = 0;
  int res_stall = 0;
  logic [31:0] resp_data = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dcache model: owns cmd_ready, dcache_valid, dcache_dout
  initial begin : dcache_model
    logic [31:0] s_addr, s_din;
    logic [2:0]  s_size;
    logic        s_we;
    bit          seen, pend, rdy_prev;
    int          stall, cnt, flush_seen;
    cmd_t        e;
    bus.dcache_cmd_ready = 1'b0;
    bus.dcache_valid = 1'b0;
    bus.dcache_dout = 32'd0;
    seen = 0; pend = 0; rdy_prev = 0; stall = 0; cnt = 0; flush_seen = 0;
    s_addr = 0; s_din = 0; s_size = 0; s_we = 0;
    forever begin
      @(negedge clk);
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        bus.dcache_cmd_ready = 1'b0;
        bus.dcache_valid = 1'b0;
        seen = 0; pend = 0; rdy_prev = 0;
      end else begin
        if (bus.dcache_cmd_ready) begin
          bus.dcache_cmd_ready = 1'b0;
          seen = 0; pend = 1; cnt = 0;
        end else if (bus.dcache_cmd_valid) begin
          if (!seen) begin
            seen = 1; stall = 0; ncmds++;
            s_addr = bus.dcache_cmd_addr; s_size = bus.dcache_cmd_size;
            s_we = bus.dcache_cmd_we; s_din = bus.dcache_din;
            if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(bus.dcache_cmd_valid), 32'd0);
            else begin
              e = exp_cmd.pop_front();
              chk("cmd_addr", s_addr, e.addr);
              chk("cmd_size", 32'(s_size), 32'(e.size));
              chk("cmd_we", 32'(s_we), 32'(e.we));
              chk("cmd_din", s_din, e.din);
            end
          end else begin
            chk("cmd_addr_stable", bus.dcache_cmd_addr, s_addr);
            chk("cmd_din_stable", bus.dcache_din, s_din);
            chk("cmd_size_stable", 32'(bus.dcache_cmd_size), 32'(s_size));
            chk("cmd_we_stable", 32'(bus.dcache_cmd_we), 32'(s_we));
          end
          if (stall >= cmd_stall) bus.dcache_cmd_ready = 1'b1;
          else stall++;
        end
        if (bus.dcache_valid && rdy_prev) begin
          bus.dcache_valid = 1'b0;
          pend = 0;
        end else if (pend && !bus.dcache_valid) begin
          if (cnt >= resp_delay) begin
            bus.dcache_valid = 1'b1;
            bus.dcache_dout = resp_data;
          end else cnt++;
        end
        rdy_prev = bus.dcache_ready;
      end
    end
  end

  // result monitor: owns lsu_ready
  initial begin : res_mon
    res_t        e;
    logic [31:0] s_dout;
    logic        s_exc;
    bit          seen;
    int          stall;
    bus.lsu_ready = 1'b0;
    seen = 0; stall = 0; s_dout = 0; s_exc = 0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.lsu_valid || bus.dcache_cmd_valid || bus.dcache_ready))
        chk("op_ready_busy", 32'(bus.lsu_op_ready), 32'd0);
      if (bus.lsu_ready) begin
        bus.lsu_ready = 1'b0;
        seen = 0;
        results_done++;
      end else if (bus.lsu_valid) begin
        if (!seen) begin
          seen = 1; stall = 0;
          s_dout = bus.lsu_dout; s_exc = bus.lsu_exc_align;
          if (exp_res.size() == 0) chk("res_unexpected", 32'(bus.lsu_valid), 32'd0);
          else begin
            e = exp_res.pop_front();
            chk("res_dout", s_dout, e.dout);
            chk("res_exc", 32'(s_exc), 32'(e.exc));
            chk("res_latency", cyc - issue_cyc, e.lat);
          end
        end else begin
          chk("res_dout_stable", bus.lsu_dout, s_dout);
          chk("res_exc_stable", 32'(bus.lsu_exc_align), 32'(s_exc));
        end
        if (stall >= res_stall) bus.lsu_ready = 1'b1;
        else stall++;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    chk({tag, "_op_ready"}, 32'(bus.lsu_op_ready), 32'd1);
    chk({tag, "_lsu_valid"}, 32'(bus.lsu_valid), 32'd0);
    chk({tag, "_exc"}, 32'(bus.lsu_exc_align), 32'd0);
    chk({tag, "_dout"}, bus.lsu_dout, 32'd0);
    chk({tag, "_cmd_valid"}, 32'(bus.dcache_cmd_valid), 32'd0);
    chk({tag, "_dc_ready"}, 32'(bus.dcache_ready), 32'd0);
    chk({tag, "_cmd_addr"}, bus.dcache_cmd_addr, 32'd0);
    chk({tag, "_cmd_size"}, 32'(bus.dcache_cmd_size), 32'd0);
    chk({tag, "_cmd_we"}, 32'(bus.dcache_cmd_we), 32'd0);
    chk({tag, "_din"}, bus.dcache_din, 32'd0);
  endtask

  task automatic drive_op(input logic load, input logic [2:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdat);
    int k;
    k = 0;
    while (!bus.lsu_op_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("op_ready_idle", 32'(bus.lsu_op_ready), 32'd1);
    bus.lsu_op_load = load;
    bus.lsu_op_size = size;
    bus.lsu_op_sign = sign;
    bus.lsu_op_addr = addr;
    bus.lsu_op_wdat = wdat;
    bus.lsu_op_valid = 1'b1;
    issue_cyc = cyc;
    @(negedge clk);
    bus.lsu_op_valid = 1'b0;
    chk("op_accepted", 32'(bus.lsu_op_ready), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int base_cmds, base_res, k;
    cmd_stall = v.cs;
    resp_delay = v.rd;
    res_stall = v.rs;
    resp_data = v.rdat;
    if (!v.e_exc) exp_cmd.push_back('{v.e_addr, v.e_size, ~v.load, v.e_din});
    exp_res.push_back('{v.e_dout, v.e_exc, v.e_lat});
    base_cmds = ncmds;
    base_res = results_done;
    drive_op(v.load, v.size, v.sign, v.addr, v.wdat);
    k = 0;
    while (results_done != base_res + 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("result_count", results_done, base_res + 1);
    repeat (2) @(negedge clk);
    chk("cmd_count", ncmds - base_cmds, v.e_exc ? 0 : 1);
    chk("no_extra_result", 32'(bus.lsu_valid), 32'd0);
  endtask

  initial begin : stim
    int base, k;
    rst = 1'b1;
    bus.lsu_op_valid = 1'b0;
    bus.lsu_op_load = 1'b0;
    bus.lsu_op_size = 3'd0;
    bus.lsu_op_sign = 1'b0;
    bus.lsu_op_addr = 32'd0;
    bus.lsu_op_wdat = 32'd0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    //           ld   size  sg  addr          wdat          rdat          cs rd rs  e_addr        esz   e_din         e_dout        exc lat
    vt.push_back('{1'b1, 3'd2, 1'b0, 32'h0000_0100, 32'h0,        32'h89AB_CDEF, 0, 0, 0, 32'h0000_0100, 3'd2, 32'h0,        32'h89AB_CDEF, 1'b0, 3});
    vt.push_back('{1'b1, 3'd0, 1'b1, 32'h0000_0203, 32'h0,        32'h8011_2233, 0, 0, 0, 32'h0000_0200, 3'd0, 32'h0,        32'hFFFF_FF80, 1'b0, 3});
    vt.push_back('{1'b1, 3'd0, 1'b0, 32'h0000_0203, 32'h0,        32'h8011_2233, 0, 0, 0, 32'h0000_0200, 3'd0, 32'h0,        32'h0000_0080, 1'b0, 3});
    vt.push_back('{1'b0, 3'd1, 1'b0, 32'h0000_0302, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_0300, 3'd1, 32'hBEEF_BEEF, 32'h0,        1'b0, 3});
    vt.push_back('{1'b1, 3'd2, 1'b0, 32'h0000_0401, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3'd0, 32'h0,        32'h0,        1'b1, 1});
    vt.push_back('{1'b1, 3'd1, 1'b1, 32'h0000_0506, 32'h0,        32'h8001_7FFF, 3, 4, 2, 32'h0000_0504, 3'd1, 32'h0,        32'hFFFF_8001, 1'b0, 10});
    vt.push_back('{1'b0, 3'd1, 1'b0, 32'h0000_0603, 32'h1234_5678, 32'h0,        0, 0, 0, 32'h0,        3'd0, 32'h0,        32'h0,        1'b1, 1});
    vt.push_back('{1'b0, 3'd0, 1'b0, 32'h0000_0701, 32'h1234_56A5, 32'h0,        0, 0, 0, 32'h0000_0700, 3'd0, 32'hA5A5_A5A5, 32'h0,        1'b0, 3});
    vt.push_back('{1'b1, 3'd1, 1'b0, 32'h0000_0800, 32'h0,        32'h1234_F00D, 0, 0, 0, 32'h0000_0800, 3'd1, 32'h0,        32'h0000_F00D, 1'b0, 3});
    vt.push_back('{1'b0, 3'd2, 1'b0, 32'h0000_0904, 32'hCAFE_BABE, 32'h0,        0, 1, 1, 32'h0000_0904, 3'd2, 32'hCAFE_BABE, 32'h0,        1'b0, 4});
    vt.push_back('{1'b1, 3'd3, 1'b1, 32'h0000_0A00, 32'h0,        32'h1122_3344, 0, 0, 0, 32'h0000_0A00, 3'd2, 32'h0,        32'h1122_3344, 1'b0, 3});
    vt.push_back('{1'b1, 3'd7, 1'b0, 32'h0000_0A02, 32'h0,        32'h0,        0, 0, 0, 32'h0,        3'd0, 32'h0,        32'h0,        1'b1, 1});
    vt.push_back('{1'b1, 3'd0, 1'b1, 32'h0000_0B01, 32'h0,        32'h0000_7F00, 0, 0, 0, 32'h0000_0B00, 3'd0, 32'h0,        32'h0000_007F, 1'b0, 3});

    foreach (vt[i]) run_vec(vt[i]);

    // Reset while the dcache response is outstanding.
    cmd_stall = 0;
    resp_delay = 30;
    res_stall = 0;
    resp_data = 32'h5555_AAAA;
    exp_cmd.push_back('{32'h0000_0C04, 3'd2, 1'b0, 32'h0});
    base = ncmds;
    drive_op(1'b1, 3'd2, 1'b0, 32'h0000_0C04, 32'h0);
    k = 0;
    while (!bus.dcache_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_resp", 32'(bus.dcache_ready), 32'd1);
    rst = 1'b1;
    flush_req++;
    @(negedge clk);
    check_reset("rst_in_resp");
    rst = 1'b0;
    chk("rst_cmd_count", ncmds - base, 1);
    @(negedge clk);
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ncpu32k_lsu.md
# ncpu32k_lsu

Load/store unit. Sits directly upstream of the data cache. It accepts one load or store operation at a time from the execute stage and checks the address for natural alignment. It places store data into the correct byte lanes and issues a single command on the dcache command channel. It then waits for the dcache response, and returns sign- or zero-extended load data, or a store completion, to the pipeline. It also flags misaligned accesses without issuing any bus traffic.

## Interface
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes little-endian)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- lsu_op_valid  in  1  operation presented by execute stage
- lsu_op_ready  out  1  LSU can accept an operation
- lsu_op_load  in  1  1 = load, 0 = store
- lsu_op_size  in  3  0 = byte, 1 = halfword, 2 = word; other codes are treated as word
- lsu_op_sign  in  1  load sign-extend (ignored for word and store)
- lsu_op_addr  in  AW  effective address
- lsu_op_wdat  in  DW  store data, right-justified
- lsu_valid  out  1  result available
- lsu_ready  in  1  pipeline accepts result
- lsu_dout  out  DW  extended load data (0 for stores)
- lsu_exc_align  out  1  result is a misalignment exception (valid with lsu_valid)
- dcache_cmd_valid  out  1  command presented to dcache
- dcache_cmd_ready  in  1  dcache accepts command
- dcache_cmd_addr  out  AW  word-aligned address (addr[1:0] forced 0)
- dcache_cmd_size  out  3  byte/half/word code, as lsu_op_size
- dcache_cmd_we  out  1  1 = store
- dcache_din  out  DW  lane-placed store data
- dcache_valid  in  1  response (load data or store ack) presented
- dcache_ready  out  1  LSU accepts response
- dcache_dout  in  DW  raw 32-bit word read

## Operation
- State machine states:
  - IDLE: lsu_op_ready=1. On lsu_op_valid, latch addr, size, sign, load and lane-placed wdat.
    - If aligned, go to CMD.
    - If misaligned, set the exception flag and go to DONE.
  - CMD: dcache_cmd_valid=1, with all command outputs stable from the latched registers. On dcache_cmd_ready, go to RESP.
  - RESP: dcache_ready=1. On dcache_valid, capture the extracted and extended data (loads) or 0 (stores), then go to DONE.
  - DONE: lsu_valid=1, with lsu_dout and lsu_exc_align stable. On lsu_ready, go to IDLE.
- Alignment rule:
  - half: misaligned if addr[0]=1.
  - word: misaligned if addr[1:0]≠0.
  - byte: never misaligned.
- Store lane placement: byte → wdat[7:0] replicated to all 4 lanes; half → wdat[15:0] replicated to both halves; word unchanged. Byte enables are conveyed by size plus the low address bits, carried on dcache_cmd_addr's latched copy internally only.
- Load extraction:
  - byte lane = addr[1:0] (lane 0 = bits 7:0).
  - half lane = addr[1] (0 = bits 15:0).
  - Extend by lsu_op_sign: sign-extend if set, zero-extend otherwise.
- Exception results: lsu_dout=0 and no dcache command is ever issued.

## Timing
- Reset values: state=IDLE; lsu_op_ready=1; lsu_valid=0; lsu_exc_align=0; lsu_dout=0; dcache_cmd_valid=0; dcache_ready=0; dcache_cmd_addr/size/we/din=0.
- Minimum aligned latency:
  - op accepted cycle 0.
  - cmd_valid cycle 1; with cmd_ready=1 the handshake completes in cycle 1.
  - response accepted cycle 2 earliest.
  - lsu_valid cycle 3.
- Misaligned: accepted cycle 0, lsu_valid cycle 1.
- dcache_valid seen while not in RESP is ignored; the dcache holds it until dcache_ready.
- Command outputs must not change while cmd_valid=1 and cmd_ready=0.
- lsu_op_ready=0 in CMD, RESP and DONE. There is no overlap: the next op is accepted no earlier than the cycle after DONE→IDLE.
- Back-pressure in DONE (lsu_ready=0) holds lsu_valid and lsu_dout indefinitely.
- Reset asserted in any state returns to IDLE next edge and drops all handshake outputs; an outstanding dcache transaction is abandoned.

## Test plan
- Word load at 0x100: cmd_ready=1, dcache_dout=0x89ABCDEF one cycle later → cmd addr 0x100, size 2, we 0; lsu_dout=0x89ABCDEF, lsu_valid in cycle 3.
- Signed byte load at 0x203, dcache_dout=0x80112233 → cmd addr 0x200, size 0; lsu_dout=0xFFFFFF80. Same with sign=0 → 0x00000080.
- Halfword store of wdat=0x0000BEEF at 0x302 → dcache_din=0xBEEFBEEF, we=1, size 1; after ack lsu_valid=1, lsu_dout=0, exc=0.
- Misaligned word load at 0x401 → no dcache_cmd_valid ever; lsu_valid next cycle with lsu_exc_align=1.
- Stalls: cmd_ready low 3 cycles, dcache_valid delayed 4 cycles, lsu_ready low 2 cycles → outputs held stable, no duplicate command, single result.
- Reset asserted while in RESP → next cycle all outputs at reset values, lsu_op_ready=1; a following load completes normally.
